fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register directly upstream of the instruction decoder.
- Owns the PC and issues one-outstanding-request reads to instruction memory.
- Presents the 32-bit instruction word `ins` to the decoder, or 0 (decoded as nop) when no instruction is available.
- Consumes the decoder's `jump`/`jr` outputs to redirect the PC and flush wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard stall; freezes the IF/ID register
- jump  in  1  decoder j/jal indication for the current `ins`
- jr  in  1  decoder jr indication for the current `ins`
- jr_target  in  32  register-file rs value for jr
- imem_req  out  1  read request, level; address must stay stable while high
- imem_addr  out  32  byte address of the request (= pc)
- imem_valid  in  1  response strobe; sampled only while imem_req=1; may be asserted in the same cycle as the request (zero-wait memory)
- imem_rdata  in  32  instruction word, valid with imem_valid
- ins  out  32  IF/ID instruction to the decoder
- ins_valid  out  1  ins holds a real instruction
- pc_id  out  32  address of ins
- pc_plus4  out  32  pc_id+4, used as the jal link value

Behaviour:
- Reset values:
  - pc=RESET_PC, state=IDLE, ins=0, ins_valid=0, pc_id=0, imem_req=0.
  - buf, buf_pc and redir_pc reset to 0.
- imem_req=1 in states REQ and DISCARD; imem_addr=pc.
- Redirect condition: redirect = ins_valid & !stall & (jr | jump).
  - jr has priority: target = jr_target.
  - Otherwise (jump): target = {pc_plus4[31:28], ins[25:0], 2'b00}.
- IDLE: next cycle -> REQ. IDLE is only reached from reset; first request is in the 1st cycle after rst deasserts.
- REQ, in priority order:
  - redirect & imem_valid: drop rdata; pc<=target; ins<=0, ins_valid<=0; stay REQ.
  - redirect & !imem_valid: redir_pc<=target; ins<=0, ins_valid<=0; -> DISCARD (pc held so imem_addr stays stable).
  - imem_valid & !stall: ins<=rdata, ins_valid<=1, pc_id<=pc; pc<=pc+4; stay REQ. Throughput is 1 instruction/cycle with zero-wait memory.
  - imem_valid & stall: buf<=rdata, buf_pc<=pc; pc<=pc+4; ins unchanged; -> BUF.
  - !imem_valid & !stall: ins<=0, ins_valid<=0 (bubble); stay REQ.
  - !imem_valid & stall: everything held.
- BUF (imem_req=0):
  - stall: hold everything.
  - !stall & redirect: drop buf; pc<=target; ins<=0, ins_valid<=0; -> REQ.
  - !stall, no redirect: ins<=buf, ins_valid<=1, pc_id<=buf_pc; -> REQ.
- DISCARD:
  - wait for imem_valid; drop the response; pc<=redir_pc; -> REQ.
  - ins stays 0 / ins_valid stays 0 while in this state, regardless of stall.
  - A jump/jr arriving in DISCARD is impossible (ins_valid=0) and is ignored.
- Stall semantics: while stall=1, ins, ins_valid and pc_id never change. The only exceptions are the redirect-free BUF capture and the DISCARD hold, neither of which touches them.
- Each valid instruction is presented on ins for exactly the cycles up to and including its first non-stalled cycle.
- Arithmetic: pc+4 and pc_id+4 are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
- PC alignment: the low 2 bits of pc are not forced. jr_target misalignment passes through unchanged.
- Reset mid-operation: asynchronous return to reset values. The instruction memory is reset by the same rst, so no stale response arrives.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] and flush_cnt[31:0], both reset to 0, wrapping.
  - fetch_cnt increments on every accepted response (REQ with imem_valid and no redirect).
  - flush_cnt increments on every redirect that kills an instruction or response: dropped rdata, DISCARD entry, or dropped buf.
- Undefined: the two ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, zero-wait memory returning addr as data -> imem_req first high 1 cycle after rst falls, imem_addr=0x40; next cycles show ins=0x40, 0x44, 0x48, one per cycle, ins_valid=1.
- ins=32'h0800_0010 (j), pc_id=0x48, jump=1 -> next imem_addr=0x40; ins=0 and ins_valid=0 for one cycle; next valid ins comes from 0x40.
- 3-cycle-latency memory, jr=1 with jr_target=0x100 while a request to 0x50 is outstanding -> imem_addr stays 0x50 until imem_valid; that response is dropped; then imem_addr=0x100; ins_valid stays 0 throughout.
- stall=1 for 4 cycles while the response for 0x60 arrives -> ins/pc_id frozen; imem_req=0 during BUF; after stall drops, ins=word@0x60, pc_id=0x60, then the fetch at 0x64 follows.
- pc_id=32'hFFFF_FFFC -> pc_plus4=0; sequential fetch wraps to imem_addr=0.
- With FETCH_PERF_CNT_EN: 10 sequential fetches plus 2 redirects -> fetch_cnt=10, flush_cnt=2. Assert rst mid-run -> both counters read 0 immediately, asynchronously.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction-memory port and decoder-side IF/ID signals
interface fetch_unit_if;
  logic        stall;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4;

  modport master (
    input  stall, jump, jr, jr_target, imem_valid, imem_rdata,
    output imem_req, imem_addr, ins, ins_valid, pc_id, pc_plus4
  );

  modport slave (
    output stall, jump, jr, jr_target, imem_valid, imem_rdata,
    input  imem_req, imem_addr, ins, ins_valid, pc_id, pc_plus4
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage and IF/ID register with one outstanding imem read
// Optional fetch/flush performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, BUF, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req;
  logic [31:0] ins_r;
  logic        ins_valid_r;
  logic [31:0] pc_id_r;
  logic [31:0] buf_word;
  logic [31:0] buf_pc;
  logic [31:0] redir_pc;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_id_r + 32'd4;
  assign redirect = ins_valid_r & ~bus.stall & (bus.jr | bus.jump);
  assign target   = bus.jr ? bus.jr_target : {pc_plus4[31:28], ins_r[25:0], 2'b00};

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.ins       = ins_r;
  assign bus.ins_valid = ins_valid_r;
  assign bus.pc_id     = pc_id_r;
  assign bus.pc_plus4  = pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req         <= 1'b0;
      ins_r       <= 32'd0;
      ins_valid_r <= 1'b0;
      pc_id_r     <= 32'd0;
      buf_word    <= 32'd0;
      buf_pc      <= 32'd0;
      redir_pc    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (redirect) begin
            ins_r       <= 32'd0;
            ins_valid_r <= 1'b0;
            // Without a response in hand the address must stay put, so park the target.
            if (bus.imem_valid) begin
              pc <= target;
            end else begin
              redir_pc <= target;
              state    <= DISCARD;
            end
          end else if (bus.imem_valid) begin
            pc <= pc + 32'd4;
            if (bus.stall) begin
              buf_word <= bus.imem_rdata;
              buf_pc   <= pc;
              state    <= BUF;
              req      <= 1'b0;
            end else begin
              ins_r       <= bus.imem_rdata;
              ins_valid_r <= 1'b1;
              pc_id_r     <= pc;
            end
          end else if (!bus.stall) begin
            ins_r       <= 32'd0;
            ins_valid_r <= 1'b0;
          end
        end
        BUF: begin
          if (!bus.stall) begin
            state <= REQ;
            req   <= 1'b1;
            if (redirect) begin
              pc          <= target;
              ins_r       <= 32'd0;
              ins_valid_r <= 1'b0;
            end else begin
              ins_r       <= buf_word;
              ins_valid_r <= 1'b1;
              pc_id_r     <= buf_pc;
            end
          end
        end
        DISCARD: begin
          if (bus.imem_valid) begin
            pc    <= redir_pc;
            state <= REQ;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic accept;
  logic kill;

  assign accept = (state == REQ) & bus.imem_valid & ~redirect;
  assign kill   = redirect & ((state == REQ) | (state == BUF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (kill)   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit against a program-order fetch model
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0040;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Instruction memory image: a few directed words, identity below 0x100, scrambled above.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h48) return 32'h0800_0010;
    if (a < 32'h100) return a;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F17;
  endfunction

  int unsigned stall_pct = 0;
  int unsigned redir_pct = 0;
  int unsigned lat_max   = 0;
  bit          force_jump_en = 1'b0;
  logic [31:0] force_jump_addr = 32'h0;
  bit          force_jr_once = 1'b0;
  logic [31:0] force_jr_target = 32'h0;

  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  int          exp_fetch = 0, exp_flush = 0, pend_fetch = 0, pend_flush = 0;
  int          n_consumed = 0;

  // Driver: instruction memory with random latency plus a random decoder; owns the reference model.
  initial begin
    bit          busy, discarding, buf_check, consume, redirect;
    int unsigned lat;
    logic [31:0] req_addr, w, nxt, p4;
    busy = 0; discarding = 0; buf_check = 0; lat = 0; req_addr = 0;
    bus.stall = 0; bus.jump = 0; bus.jr = 0; bus.jr_target = 0;
    bus.imem_valid = 0; bus.imem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.stall = 0; bus.jump = 0; bus.jr = 0; bus.imem_valid = 0;
        busy = 0; discarding = 0; buf_check = 0;
        exp_fetch = 0; exp_flush = 0; pend_fetch = 0; pend_flush = 0;
        exp_q.delete();
        model_pc = RPC;
        exp_q.push_back(RPC);
      end else begin
        exp_fetch += pend_fetch;
        exp_flush += pend_flush;
        pend_fetch = 0;
        pend_flush = 0;
        if (bus.imem_valid) begin
          busy = 0;
          discarding = 0;
        end
        if (buf_check) begin
          check32("imem_req_low_while_buffered", 32'(bus.imem_req), 32'd0);
          buf_check = 0;
        end

        bus.imem_valid = 0;
        if (bus.imem_req) begin
          if (!busy) begin
            busy = 1;
            req_addr = bus.imem_addr;
            lat = $urandom_range(lat_max);
          end else begin
            check32("imem_addr_stable", bus.imem_addr, req_addr);
          end
          if (lat == 0) begin
            bus.imem_valid = 1;
            bus.imem_rdata = mem_word(req_addr);
          end else begin
            lat--;
          end
        end

        bus.stall = ($urandom_range(99) < stall_pct);
        consume = bus.ins_valid && !bus.stall;
        bus.jump = 1'($urandom_range(1));
        bus.jr = 1'($urandom_range(1));
        bus.jr_target = $urandom;
        redirect = 0;
        if (consume) begin
          bus.jump = 0;
          bus.jr = 0;
          if (force_jump_en && model_pc == force_jump_addr) begin
            bus.jump = 1;
          end else if (force_jr_once) begin
            bus.jr = 1;
            bus.jr_target = force_jr_target;
            force_jr_once = 0;
          end else if ($urandom_range(99) < redir_pct) begin
            bus.jump = 1'($urandom_range(1));
            bus.jr = bus.jump ? 1'($urandom_range(1)) : 1'b1;
          end
          w = mem_word(model_pc);
          p4 = model_pc + 32'd4;
          if (bus.jr) nxt = bus.jr_target;
          else if (bus.jump) nxt = {p4[31:28], w[25:0], 2'b00};
          else nxt = p4;
          exp_q.push_back(nxt);
          model_pc = nxt;
          n_consumed++;
          redirect = bus.jump || bus.jr;
        end

        if (bus.imem_valid && !discarding && !redirect) pend_fetch = 1;
        if (redirect) pend_flush = 1;
        if (bus.imem_valid && bus.stall && !discarding) buf_check = 1;
        if (redirect && bus.imem_req && !bus.imem_valid) discarding = 1;
      end
    end
  end

  // Monitor: pops the expected fetch stream on every consumed instruction; checks stall freeze.
  initial begin
    bit          h_armed;
    logic [31:0] h_ins, h_pc, e;
    logic        h_valid;
    h_armed = 0; h_ins = 0; h_pc = 0; h_valid = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_armed = 0;
      end else begin
        if (!bus.ins_valid) check32("ins_zero_when_invalid", bus.ins, 32'd0);
        if (h_armed) begin
          check32("stall_hold_ins", bus.ins, h_ins);
          check32("stall_hold_pc_id", bus.pc_id, h_pc);
          check32("stall_hold_ins_valid", 32'(bus.ins_valid), 32'(h_valid));
        end
        h_armed = bus.stall;
        h_ins = bus.ins;
        h_pc = bus.pc_id;
        h_valid = bus.ins_valid;
        if (bus.ins_valid && !bus.stall) begin
          if (exp_q.size() == 0) begin
            check32("unexpected_instruction", bus.pc_id, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check32("stream_pc_id", bus.pc_id, e);
            check32("stream_ins", bus.ins, mem_word(e));
            check32("stream_pc_plus4", bus.pc_plus4, e + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    check32("reset_ins", bus.ins, 32'd0);
    check32("reset_ins_valid", 32'(bus.ins_valid), 32'd0);
    check32("reset_pc_id", bus.pc_id, 32'd0);
    check32("reset_imem_req", 32'(bus.imem_req), 32'd0);
    check32("reset_imem_addr", bus.imem_addr, RPC);
`ifdef FETCH_PERF_CNT_EN
    check32("reset_fetch_cnt", fetch_cnt, 32'd0);
    check32("reset_flush_cnt", flush_cnt, 32'd0);
`endif

    // Zero-wait memory, no stalls, a j at 0x48 looping back to 0x40.
    force_jump_en = 1'b1;
    force_jump_addr = 32'h48;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check32("idle_no_req", 32'(bus.imem_req), 32'd0);
    @(posedge clk); #4;
    check32("first_req", 32'(bus.imem_req), 32'd1);
    check32("first_addr", bus.imem_addr, 32'h40);
    check32("first_ins_valid", 32'(bus.ins_valid), 32'd0);
    @(posedge clk); #4;
    check32("seq0_ins", bus.ins, 32'h40);
    check32("seq0_valid", 32'(bus.ins_valid), 32'd1);
    @(posedge clk); #4;
    check32("seq1_ins", bus.ins, 32'h44);
    check32("seq1_valid", 32'(bus.ins_valid), 32'd1);
    @(posedge clk); #4;
    check32("jump_ins", bus.ins, 32'h0800_0010);
    check32("jump_pc_id", bus.pc_id, 32'h48);
    @(posedge clk); #4;
    check32("jump_bubble_valid", 32'(bus.ins_valid), 32'd0);
    check32("jump_bubble_ins", bus.ins, 32'd0);
    check32("jump_target_addr", bus.imem_addr, 32'h40);
    @(posedge clk); #4;
    check32("after_jump_ins", bus.ins, 32'h40);
    check32("after_jump_pc_id", bus.pc_id, 32'h40);
`ifdef FETCH_PERF_CNT_EN
    check32("dir_fetch_cnt", fetch_cnt, 32'd4);
    check32("dir_flush_cnt", flush_cnt, 32'd1);
`endif

    // jr to the top of the address space, then sequential wrap to 0.
    force_jump_en = 1'b0;
    force_jr_target = 32'hFFFF_FFF8;
    force_jr_once = 1'b1;
    stall_pct = 20;
    lat_max = 2;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #4;
      if (bus.ins_valid && bus.pc_id == 32'hFFFF_FFFC) found = 1;
    end
    check32("wrap_top_reached", 32'(found), 32'd1);
    if (found) check32("wrap_pc_plus4", bus.pc_plus4, 32'd0);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #4;
      if (bus.ins_valid && bus.pc_id == 32'd0) found = 1;
    end
    check32("wrap_to_zero", 32'(found), 32'd1);

    stall_pct = 30;
    redir_pct = 15;
    lat_max = 3;
    repeat (3000) @(posedge clk);

    // Asynchronous reset in the middle of traffic.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check32("midrst_ins_valid", 32'(bus.ins_valid), 32'd0);
    check32("midrst_ins", bus.ins, 32'd0);
    check32("midrst_pc_id", bus.pc_id, 32'd0);
    check32("midrst_imem_req", 32'(bus.imem_req), 32'd0);
    check32("midrst_imem_addr", bus.imem_addr, RPC);
`ifdef FETCH_PERF_CNT_EN
    check32("midrst_fetch_cnt", fetch_cnt, 32'd0);
    check32("midrst_flush_cnt", flush_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (500) @(posedge clk);

    stall_pct = 0;
    redir_pct = 0;
    repeat (20) @(posedge clk);
    #4;
`ifdef FETCH_PERF_CNT_EN
    check32("final_fetch_cnt", fetch_cnt, 32'(exp_fetch));
    check32("final_flush_cnt", flush_cnt, 32'(exp_flush));
`endif
    check32("progress", 32'(n_consumed > 1000), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
